// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS datapath register-file slice.
package mips_pkg;

  localparam int REG_ZERO   = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

  // Bit offset of field `port` in a bus built from `width`-bit fields packed LSB first.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/mips_pend_scoreboard.sv
// Per-register pending bits for long-latency ops, per-port stall flags and a running pending count.
module mips_pend_scoreboard
  import mips_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int NUM_RD = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_pend,
  output logic [ADDR_W:0]          pend_count
);

  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic             rsv_hit;
  logic             wr1_hit;
  logic             set_rise;
  logic             clr_fall;

  assign rsv_hit = rsv_en && (rsv_addr != ADDR_W'(REG_ZERO));
  assign wr1_hit = wr1_en && (wr1_addr != ADDR_W'(REG_ZERO));

  // A reserve landing on the same register as a returning write belongs to a newer op, so it wins.
  assign set_rise = rsv_hit && !pend[rsv_addr];
  assign clr_fall = wr1_hit && pend[wr1_addr] && !(rsv_hit && (rsv_addr == wr1_addr));

  always_comb begin
    pend_nxt = pend;
    if (wr1_hit) pend_nxt[wr1_addr] = 1'b0;
    if (rsv_hit) pend_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      pend_count <= '0;
    end else begin
      pend       <= pend_nxt;
      pend_count <= pend_count + CNT_W'(set_rise) - CNT_W'(clr_fall);
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_pend
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
    assign rd_pend[i] = pend[a] & ~(wr1_en & (wr1_addr == a) & ~(rsv_en & (rsv_addr == a)));
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// Parametrised multi-port MIPS register file: two write ports with bypass, hard-wired r0, pending scoreboard.
module mips_regfile_mp
  import mips_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int NUM_RD = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          pend_count
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr0_hit;
  logic              wr1_hit;

  assign wr1_hit = wr1_en && (wr1_addr != ADDR_W'(REG_ZERO));
  // On a same-address collision the long-latency return owns the register.
  assign wr0_hit = wr0_en && (wr0_addr != ADDR_W'(REG_ZERO)) && !(wr1_hit && (wr1_addr == wr0_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      if (wr0_hit) regs[wr0_addr] <= wr0_data;
      if (wr1_hit) regs[wr1_addr] <= wr1_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];

    // Bypass is gated by reset so nothing leaks out while the file is held cleared.
    always_comb begin
      d = regs[a];
      if (a != ADDR_W'(REG_ZERO)) begin
        if (wr1_en && (wr1_addr == a))      d = wr1_data;
        else if (wr0_en && (wr0_addr == a)) d = wr0_data;
      end else begin
        d = '0;
      end
      if (!rst_n) d = '0;
    end

    assign rd_data[port_lsb(i, DATA_W) +: DATA_W] = d;
  end

  mips_pend_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) u_pend (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .rd_addr    (rd_addr),
    .rd_pend    (rd_pend),
    .pend_count (pend_count)
  );

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed bench for mips_regfile_mp: default 32x32/2-port instance plus a 16-bit, 8-deep, 4-port instance.
module tb_mips_regfile_mp;

  logic clk;
  logic rst_n;

  // default configuration
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic        wr0_en, wr1_en, rsv_en;
  logic [4:0]  wr0_addr, wr1_addr, rsv_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [5:0]  pend_count;

  // narrow configuration
  logic [11:0] s_rd_addr;
  logic [63:0] s_rd_data;
  logic [3:0]  s_rd_pend;
  logic        s_wr0_en, s_wr1_en, s_rsv_en;
  logic [2:0]  s_wr0_addr, s_wr1_addr, s_rsv_addr;
  logic [15:0] s_wr0_data, s_wr1_data;
  logic [3:0]  s_pend_count;

  logic [31:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  mips_regfile_mp u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pend    (rd_pend),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .pend_count (pend_count)
  );

  mips_regfile_mp #(
    .DATA_W (16),
    .DEPTH  (8),
    .NUM_RD (4)
  ) u_dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (s_rd_addr),
    .rd_data    (s_rd_data),
    .rd_pend    (s_rd_pend),
    .wr0_en     (s_wr0_en),
    .wr0_addr   (s_wr0_addr),
    .wr0_data   (s_wr0_data),
    .wr1_en     (s_wr1_en),
    .wr1_addr   (s_wr1_addr),
    .wr1_data   (s_wr1_data),
    .rsv_en     (s_rsv_en),
    .rsv_addr   (s_rsv_addr),
    .pend_count (s_pend_count)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after the rising edge, outputs sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // scoreboard: pop the oldest expectation and compare against the observed DUT value
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    chk_cnt++;
    if (exp_q.size() == 0) begin
      fail_cnt++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rd_addr = '0; wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0; rsv_en = 0; rsv_addr = '0;
    s_rd_addr = '0; s_wr0_en = 0; s_wr0_addr = '0; s_wr0_data = '0;
    s_wr1_en = 0; s_wr1_addr = '0; s_wr1_data = '0; s_rsv_en = 0; s_rsv_addr = '0;

    // reset held with a write and a reserve presented
    rst_n = 1'b0;
    wr0_en = 1; wr0_addr = 5'd9; wr0_data = 32'hFFFF_FFFF;
    rsv_en = 1; rsv_addr = 5'd9;
    rd_addr = {5'd0, 5'd9};
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data", rd_data[31:0]);
    check("rst_rd_pend", {30'd0, rd_pend});
    check("rst_pend_count", {26'd0, pend_count});

    rst_n = 1'b1; wr0_en = 0; rsv_en = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    settle();
    check("post_rst_r9", rd_data[31:0]);
    check("post_rst_pend_count", {26'd0, pend_count});

    // wr0 bypass then storage
    tick();
    wr0_en = 1; wr0_addr = 5'd9; wr0_data = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    settle();
    check("wr0_bypass", rd_data[31:0]);
    tick();
    wr0_en = 0;
    exp_q.push_back(32'hDEAD_BEEF);
    settle();
    check("wr0_stored", rd_data[31:0]);

    // writes to r0 are dropped
    tick();
    wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'h1234_5678;
    wr1_en = 1; wr1_addr = 5'd0; wr1_data = 32'h8765_4321;
    rd_addr = {5'd9, 5'd0};
    exp_q.push_back(32'h0); exp_q.push_back(32'hDEAD_BEEF);
    settle();
    check("r0_bypass", rd_data[31:0]);
    check("r9_untouched", rd_data[63:32]);
    tick();
    wr0_en = 0; wr1_en = 0;
    exp_q.push_back(32'h0);
    settle();
    check("r0_stored", rd_data[31:0]);

    // collision: wr1 wins
    tick();
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'h1111;
    wr1_en = 1; wr1_addr = 5'd5; wr1_data = 32'h2222;
    rd_addr = {5'd0, 5'd5};
    exp_q.push_back(32'h2222);
    settle();
    check("collide_bypass", rd_data[31:0]);
    tick();
    wr0_en = 0; wr1_en = 0;
    exp_q.push_back(32'h2222);
    settle();
    check("collide_stored", rd_data[31:0]);

    // reserve r3 and r7
    tick();
    rsv_en = 1; rsv_addr = 5'd3;
    tick();
    rsv_addr = 5'd7;
    tick();
    rsv_en = 0;
    rd_addr = {5'd7, 5'd3};
    exp_q.push_back(32'd2); exp_q.push_back(32'h3);
    settle();
    check("rsv_count", {26'd0, pend_count});
    check("rsv_rd_pend", {30'd0, rd_pend});

    // wr1 returns r3: unstall in the same cycle, count drops at the next edge
    tick();
    wr1_en = 1; wr1_addr = 5'd3; wr1_data = 32'h33;
    exp_q.push_back(32'h2); exp_q.push_back(32'd2); exp_q.push_back(32'h33);
    settle();
    check("wr1_unstall", {30'd0, rd_pend});
    check("wr1_count_hold", {26'd0, pend_count});
    check("wr1_bypass", rd_data[31:0]);
    tick();
    wr1_en = 0;
    exp_q.push_back(32'd1); exp_q.push_back(32'h2);
    settle();
    check("wr1_count_dec", {26'd0, pend_count});
    check("wr1_rd_pend_after", {30'd0, rd_pend});

    // reserve and wr1 on r7 together: stays pending
    tick();
    rsv_en = 1; rsv_addr = 5'd7;
    wr1_en = 1; wr1_addr = 5'd7; wr1_data = 32'h77;
    exp_q.push_back(32'h2); exp_q.push_back(32'h77);
    settle();
    check("same_reg_rd_pend", {30'd0, rd_pend});
    check("same_reg_bypass", rd_data[63:32]);
    tick();
    rsv_en = 0; wr1_en = 0;
    exp_q.push_back(32'd1); exp_q.push_back(32'h2);
    settle();
    check("same_reg_count", {26'd0, pend_count});
    check("same_reg_pend_after", {30'd0, rd_pend});

    // reserve r4 while wr1 returns r7: net zero
    tick();
    rsv_en = 1; rsv_addr = 5'd4;
    wr1_en = 1; wr1_addr = 5'd7; wr1_data = 32'h78;
    rd_addr = {5'd7, 5'd4};
    exp_q.push_back(32'h0);
    settle();
    check("swap_rd_pend", {30'd0, rd_pend});
    tick();
    rsv_en = 0; wr1_en = 0;
    exp_q.push_back(32'd1); exp_q.push_back(32'h1); exp_q.push_back(32'h78);
    settle();
    check("swap_count", {26'd0, pend_count});
    check("swap_pend_after", {30'd0, rd_pend});
    check("swap_r7_stored", rd_data[63:32]);

    // narrow configuration: four ports on distinct registers
    s_wr0_en = 1; s_wr0_addr = 3'd1; s_wr0_data = 16'hA001;
    s_wr1_en = 1; s_wr1_addr = 3'd2; s_wr1_data = 16'hB002;
    tick();
    s_wr0_addr = 3'd3; s_wr0_data = 16'hA003;
    s_wr1_addr = 3'd6; s_wr1_data = 16'hB006;
    tick();
    s_wr0_en = 0; s_wr1_en = 0;
    s_rd_addr = {3'd6, 3'd3, 3'd2, 3'd1};
    exp_q.push_back(32'hA001); exp_q.push_back(32'hB002);
    exp_q.push_back(32'hA003); exp_q.push_back(32'hB006);
    settle();
    for (int i = 0; i < 4; i++) check($sformatf("s_port%0d", i), {16'd0, s_rd_data[i*16 +: 16]});

    // reserve on r0 ignored
    s_rsv_en = 1; s_rsv_addr = 3'd0;
    s_rd_addr = {3'd0, 3'd0, 3'd0, 3'd0};
    tick();
    s_rsv_en = 0;
    exp_q.push_back(32'd0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    settle();
    check("s_rsv_r0_count", {28'd0, s_pend_count});
    check("s_rsv_r0_pend", {28'd0, s_rd_pend});
    check("s_r0_data", {16'd0, s_rd_data[15:0]});

    // fill r1..r7, then re-reserve r1: count tops out at 7
    for (int r = 1; r < 8; r++) begin
      s_rsv_en = 1; s_rsv_addr = 3'(r);
      tick();
    end
    s_rsv_addr = 3'd1;
    tick();
    s_rsv_en = 0;
    s_rd_addr = {3'd7, 3'd4, 3'd1, 3'd0};
    exp_q.push_back(32'd7); exp_q.push_back(32'he);
    settle();
    check("s_full_count", {28'd0, s_pend_count});
    check("s_full_pend", {28'd0, s_rd_pend});

    // asynchronous reset mid-sequence drops reservations and contents
    #2;
    rst_n = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'h0);
    settle();
    check("mid_rst_count", {26'd0, pend_count});
    check("mid_rst_s_count", {28'd0, s_pend_count});
    check("mid_rst_s_pend", {28'd0, s_rd_pend});
    tick();
    rst_n = 1'b1;
    rd_addr = {5'd5, 5'd9};
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    settle();
    check("mid_rst_r9", rd_data[31:0]);
    check("mid_rst_r5", rd_data[63:32]);

    if (exp_q.size() != 0) begin
      chk_cnt++;
      fail_cnt++;
      $error("FAIL leftover_expectations: observed %0d queued expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
